// File: rtl/wait_state_memory.sv
// Word-addressed memory responder that completes each request after LATENCY cycles,
// used to exercise the core's valid-stall path on the data or instruction port.
module wait_state_memory #(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_W    = 8,
    parameter int    LATENCY   = 2,
    parameter int    INIT_MEM  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic              we_re,
    input  logic [3:0]        mask,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic              valid,
    output logic [31:0]       data_out,
    output logic              busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("wait_state_memory: LATENCY must be in 1..15");
    end
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("wait_state_memory: DEPTH must equal 2**ADDR_W");
    end
    if (INIT_MEM != 0 && INIT_FILE == "") begin : g_bad_init
        $error("wait_state_memory: INIT_MEM set without INIT_FILE");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        counter, counter_next;

    logic              lat_we;
    logic [3:0]        lat_mask;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;

    logic              op_we;
    logic [3:0]        op_mask;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_data;
    logic [31:0]       byte_en;
    logic              enter_resp;

    logic [31:0]       mem [DEPTH];

    // NOTE: every signal assigned in this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        unique case (state)
            IDLE: begin
                if (request) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next   = WAIT;
                        counter_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                counter_next = counter - 4'd1;
                if (counter == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // live inputs are used in IDLE and the latched copy everywhere else.
    always_comb begin
        op_we      = (state == IDLE) ? we_re   : lat_we;
        op_mask    = (state == IDLE) ? mask    : lat_mask;
        op_addr    = (state == IDLE) ? address : lat_addr;
        op_data    = (state == IDLE) ? data_in : lat_data;
        enter_resp = (state_next == RESP) && (state != RESP);
        byte_en    = '0;
        for (int i = 0; i < 4; i++) begin
            byte_en[8*i +: 8] = {8{op_mask[i]}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= 4'd0;
            data_out <= 32'h0;
            lat_we   <= 1'b0;
            lat_mask <= 4'h0;
            lat_addr <= '0;
            lat_data <= 32'h0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (state == IDLE && request) begin
                lat_we   <= we_re;
                lat_mask <= mask;
                lat_addr <= address;
                lat_data <= data_in;
            end
            if (enter_resp && !op_we) begin
                data_out <= mem[op_addr] & byte_en;
            end
        end
    end

    // NOTE: the array has no reset; contents survive rst, and leaving it out
    // lets the storage map onto RAM macros.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (op_mask[i]) mem[op_addr][8*i +: 8] <= op_data[8*i +: 8];
            end
        end
    end

    assign valid = (state == RESP);
    assign busy  = (state != IDLE);

endmodule
